// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipe: load-use bubbles,
// branch flushes, memory freeze, halt drain and a stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_hlt,
    input  logic             branch_taken,
    input  logic             id_ex_memread,
    input  logic [3:0]       id_ex_rd,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_wen,
    output logic             mem_wb_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;

    logic st_halt;
    logic frz;
    logic drn;
    logic run_ok;
    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic hg;
    logic br;

    // Mutually exclusive, already priority-resolved decode terms.
    assign st_halt = (state == HALTED);
    assign frz     = mem_busy && !st_halt;
    assign drn     = (state == DRAIN) && !mem_busy;
    assign run_ok  = (state == RUN) && !mem_busy;
    assign rs_hit  = id_uses_rs && (id_rs == id_ex_rd);
    assign rt_hit  = id_uses_rt && (id_rt == id_ex_rd);
    assign lu      = run_ok && id_ex_memread && (id_ex_rd != 4'd0)
                     && (rs_hit || rt_hit);
    assign hg      = run_ok && !lu && id_hlt;
    assign br      = run_ok && !lu && !id_hlt && branch_taken;

    always_comb begin
        pc_wen       = 1'b1;
        if_id_wen    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_wen   = 1'b1;
        mem_wb_wen   = 1'b1;
        unique case (1'b1)
            st_halt, frz: begin
                pc_wen      = 1'b0;
                if_id_wen   = 1'b0;
                id_ex_stall = 1'b1;
                ex_mem_wen  = 1'b0;
                mem_wb_wen  = 1'b0;
            end
            drn: begin
                pc_wen       = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            lu: begin
                pc_wen       = 1'b0;
                if_id_wen    = 1'b0;
                id_ex_bubble = 1'b1;
            end
            hg: begin
                pc_wen      = 1'b0;
                if_id_flush = 1'b1;
            end
            br: begin
                if_id_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!st_halt && !pc_wen && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            unique case (state)
                RUN: begin
                    if (hg) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == '0) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                HALTED: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a
// rule-level reference model of the hazard/halt behaviour.
module tb_pipeline_hazard_ctrl;

    localparam int DC = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    id_rs;
    logic [3:0]    id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_hlt;
    logic          branch_taken;
    logic          id_ex_memread;
    logic [3:0]    id_ex_rd;
    logic          mem_busy;
    logic          pc_wen;
    logic          if_id_wen;
    logic          if_id_flush;
    logic          id_ex_stall;
    logic          id_ex_bubble;
    logic          ex_mem_wen;
    logic          mem_wb_wen;
    logic          halted;
    logic [CW-1:0] stall_count;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES(DC),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_hlt       (id_hlt),
        .branch_taken (branch_taken),
        .id_ex_memread(id_ex_memread),
        .id_ex_rd     (id_ex_rd),
        .mem_busy     (mem_busy),
        .pc_wen       (pc_wen),
        .if_id_wen    (if_id_wen),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_wen   (ex_mem_wen),
        .mem_wb_wen   (mem_wb_wen),
        .halted       (halted),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // {pc, if_id, flush, stall, bubble, ex_mem, mem_wb, halted}
    wire [7:0] outs = {pc_wen, if_id_wen, if_id_flush, id_ex_stall,
                       id_ex_bubble, ex_mem_wen, mem_wb_wen, halted};

    int checks   = 0;
    int failures = 0;

    bit m_halted;
    bit m_drain;
    int m_done;
    int m_cnt;

    function automatic bit hazard();
        bit hit;
        hit = (id_uses_rs && id_rs == id_ex_rd) ||
              (id_uses_rt && id_rt == id_ex_rd);
        return id_ex_memread && (id_ex_rd != 4'd0) && hit;
    endfunction

    function automatic logic [7:0] exp_outs();
        if (m_halted)      return 8'b0001_0001;
        else if (mem_busy) return 8'b0001_0000;
        else if (m_drain)  return 8'b0110_1110;
        else if (hazard()) return 8'b0000_1110;
        else if (id_hlt)   return 8'b0110_0110;
        else if (branch_taken) return 8'b1110_0110;
        else               return 8'b1100_0110;
    endfunction

    task automatic tick();
        logic [7:0] e;
        e = exp_outs();
        if (rst) begin
            m_halted = 0;
            m_drain  = 0;
            m_done   = 0;
            m_cnt    = 0;
        end else if (!m_halted) begin
            if (!e[7] && m_cnt < CMAX) m_cnt++;
            if (m_drain) begin
                if (!mem_busy) begin
                    m_done++;
                    if (m_done == DC) begin
                        m_halted = 1;
                        m_drain  = 0;
                    end
                end
            end else if (!mem_busy && !hazard() && id_hlt) begin
                m_drain = 1;
                m_done  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs         = 4'd0;
        id_rt         = 4'd0;
        id_uses_rs    = 1'b0;
        id_uses_rt    = 1'b0;
        id_hlt        = 1'b0;
        branch_taken  = 1'b0;
        id_ex_memread = 1'b0;
        id_ex_rd      = 4'd0;
        mem_busy      = 1'b0;
    endtask

    task automatic rand_ins();
        id_rs         = 4'($urandom_range(0, 7));
        id_rt         = 4'($urandom_range(0, 7));
        id_uses_rs    = 1'($urandom);
        id_uses_rt    = 1'($urandom);
        branch_taken  = 1'($urandom);
        id_ex_memread = 1'($urandom);
        id_ex_rd      = 4'($urandom_range(0, 7));
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rand_ins();
        id_hlt   = 1'($urandom);
        mem_busy = 1'($urandom);
        @(negedge clk);
        checks++;
        if (outs !== exp_outs()) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=%b", outs, exp_outs());
        end
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (stall_count !== '0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cnt=%0d halted=%b exp 0/0",
                     stall_count, halted);
        end
        checks++;
        if (outs !== 8'b1100_0110) begin
            failures++;
            $display("FAIL reset_enables got=%b exp=11000110", outs);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_memread = 1'b1;
        id_ex_rd      = 4'd5;
        id_rs         = 4'd5;
        id_uses_rs    = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 8'b0000_1110) begin
            failures++;
            $display("FAIL load_use_outs got=%b exp=00001110", outs);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (stall_count !== 4'd1 || outs !== 8'b1100_0110) begin
            failures++;
            $display("FAIL load_use_after cnt=%0d outs=%b exp 1/11000110",
                     stall_count, outs);
        end
    endtask

    task automatic test_reg0();
        do_reset();
        id_ex_memread = 1'b1;
        id_ex_rd      = 4'd0;
        id_rs         = 4'd0;
        id_uses_rs    = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 8'b1100_0110) begin
            failures++;
            $display("FAIL reg0 got=%b exp=11000110", outs);
        end
        tick();
        id_ex_rd   = 4'd5;
        id_rs      = 4'd3;
        id_rt      = 4'd5;
        id_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 8'b1100_0110 || stall_count !== '0) begin
            failures++;
            $display("FAIL unused_rt outs=%b cnt=%0d exp 11000110/0",
                     outs, stall_count);
        end
    endtask

    task automatic test_lu_branch();
        do_reset();
        id_ex_memread = 1'b1;
        id_ex_rd      = 4'd7;
        id_rt         = 4'd7;
        id_uses_rt    = 1'b1;
        branch_taken  = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 8'b0000_1110) begin
            failures++;
            $display("FAIL lu_branch got=%b exp=00001110", outs);
        end
        tick();
        id_ex_memread = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 8'b1110_0110) begin
            failures++;
            $display("FAIL branch_retry got=%b exp=11100110", outs);
        end
        tick();
    endtask

    task automatic test_freeze_branch();
        do_reset();
        branch_taken = 1'b1;
        mem_busy     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 8'b0001_0000) begin
                failures++;
                $display("FAIL freeze_br[%0d] got=%b exp=00010000", i, outs);
            end
            tick();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_count !== 4'd4 || outs !== 8'b1110_0110) begin
            failures++;
            $display("FAIL freeze_after cnt=%0d outs=%b exp 4/11100110",
                     stall_count, outs);
        end
    endtask

    task automatic test_halt_drain();
        bit busy_seq [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        id_hlt = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 8'b0110_0110) begin
            failures++;
            $display("FAIL hlt_issue got=%b exp=01100110", outs);
        end
        tick();
        id_hlt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_ins();
            mem_busy = busy_seq[i];
            @(negedge clk);
            checks++;
            if (outs !== exp_outs() || halted !== 1'b0) begin
                failures++;
                $display("FAIL drain[%0d] got=%b exp=%b", i, outs, exp_outs());
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || stall_count !== 4'd6) begin
            failures++;
            $display("FAIL halt_edge halted=%b cnt=%0d exp 1/6",
                     halted, stall_count);
        end
        for (int i = 0; i < 4; i++) begin
            rand_ins();
            mem_busy = 1'($urandom);
            @(negedge clk);
            checks++;
            if (outs !== 8'b0001_0001 || stall_count !== 4'd6) begin
                failures++;
                $display("FAIL halted_hold[%0d] outs=%b cnt=%0d exp 00010001/6",
                         i, outs, stall_count);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        id_hlt = 1'b1;
        tick();
        id_hlt = 1'b0;
        tick();
        rst      = 1'b1;
        mem_busy = 1'($urandom);
        @(negedge clk);
        checks++;
        if (outs !== exp_outs()) begin
            failures++;
            $display("FAIL mid_drain got=%b exp=%b", outs, exp_outs());
        end
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || stall_count !== '0 || outs !== 8'b1100_0110) begin
            failures++;
            $display("FAIL reset_drain halted=%b cnt=%0d outs=%b exp 0/0/11000110",
                     halted, stall_count, outs);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (stall_count !== m_cnt[CW-1:0]) begin
                failures++;
                $display("FAIL saturate[%0d] got=%0d exp=%0d",
                         i, stall_count, m_cnt);
            end
            tick();
        end
        mem_busy = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            rand_ins();
            id_hlt   = 1'b0;
            mem_busy = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (outs !== exp_outs() || stall_count !== m_cnt[CW-1:0]) begin
                failures++;
                $display("FAIL random[%0d] outs=%b exp=%b cnt=%0d exp=%0d",
                         i, outs, exp_outs(), stall_count, m_cnt);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reg0();
        test_lu_branch();
        test_freeze_branch();
        test_halt_drain();
        test_reset_mid_drain();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
